// File: rtl/processor_state_unit.sv
// SPARC PSR/WIM/TBR state unit with window tracking and trap entry.
// Optional maskable interrupt input enabled by PSU_INTERRUPT_EN.
module processor_state_unit #(
    parameter int unsigned NWINDOWS   = 4,
    parameter logic [7:0]  TT_ILLEGAL = 8'h02,
    parameter logic [7:0]  TT_WOVF    = 8'h05,
    parameter logic [7:0]  TT_WUNF    = 8'h06
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic [31:0] ALU_Result,
    input  logic        Condition_N,
    input  logic        Condition_Z,
    input  logic        Condition_V,
    input  logic        Condition_C,
    input  logic        ICC_Load,
    input  logic        PSR_Load,
    input  logic        WIM_Load,
    input  logic        TBR_Load,
    input  logic        Save,
    input  logic        Restore,
    input  logic        Rett,
    input  logic        Trap_Req,
    input  logic [7:0]  Trap_Type,
`ifdef PSU_INTERRUPT_EN
    input  logic [3:0]  Irl,
`endif
    output logic [31:0] PSR,
    output logic [31:0] WIM,
    output logic [31:0] TBR,
    output logic [4:0]  CWP,
    output logic        C_Out,
    output logic        Busy,
    output logic        Trap_Taken,
    output logic        Error_Mode
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP,
        ST_ERROR
    } state_e;

    localparam logic [4:0]  CWP_MAX  = 5'(NWINDOWS - 1);
    localparam logic [5:0]  NW6      = 6'(NWINDOWS);
    localparam logic [31:0] WIM_MASK = 32'((64'd1 << NWINDOWS) - 64'd1);

    state_e      state_q, state_d;
    logic [3:0]  icc_q, icc_d;
    logic [3:0]  pil_q, pil_d;
    logic        s_q, s_d;
    logic        ps_q, ps_d;
    logic        et_q, et_d;
    logic [4:0]  cwp_q, cwp_d;
    logic [31:0] wim_q, wim_d;
    logic [19:0] tba_q, tba_d;
    logic [7:0]  tt_q, tt_d;
    logic [7:0]  pend_q, pend_d;

    logic        trap_hit;
    logic [7:0]  trap_tt;
    logic [4:0]  cwp_dec;
    logic [4:0]  cwp_inc;

    always_comb begin
        cwp_dec = (cwp_q == 5'd0) ? CWP_MAX : cwp_q - 5'd1;
        cwp_inc = (cwp_q == CWP_MAX) ? 5'd0 : cwp_q + 5'd1;
    end

    always_comb begin
        state_d  = state_q;
        icc_d    = icc_q;
        pil_d    = pil_q;
        s_d      = s_q;
        ps_d     = ps_q;
        et_d     = et_q;
        cwp_d    = cwp_q;
        wim_d    = wim_q;
        tba_d    = tba_q;
        tt_d     = tt_q;
        pend_d   = pend_q;
        trap_hit = 1'b0;
        trap_tt  = 8'h00;
        unique case (state_q)
            ST_RUN: begin
                // Priority chain: only the first applicable event acts.
                if (Trap_Req) begin
                    trap_hit = 1'b1;
                    trap_tt  = Trap_Type;
                end else if ((Save && Restore) || (Rett && et_q)) begin
                    trap_hit = 1'b1;
                    trap_tt  = TT_ILLEGAL;
                end else if (PSR_Load && ({1'b0, ALU_Result[4:0]} >= NW6)) begin
                    trap_hit = 1'b1;
                    trap_tt  = TT_ILLEGAL;
                end else if (Save) begin
                    if (wim_q[cwp_dec]) begin
                        trap_hit = 1'b1;
                        trap_tt  = TT_WOVF;
                    end else begin
                        cwp_d = cwp_dec;
                    end
                end else if (Restore || Rett) begin
                    if (wim_q[cwp_inc]) begin
                        trap_hit = 1'b1;
                        trap_tt  = TT_WUNF;
                    end else begin
                        cwp_d = cwp_inc;
                        if (Rett) begin
                            s_d  = ps_q;
                            et_d = 1'b1;
                        end
                    end
                end else if (PSR_Load) begin
                    icc_d = ALU_Result[23:20];
                    pil_d = ALU_Result[11:8];
                    s_d   = ALU_Result[7];
                    ps_d  = ALU_Result[6];
                    et_d  = ALU_Result[5];
                    cwp_d = ALU_Result[4:0];
                end else if (ICC_Load) begin
                    icc_d = {Condition_N, Condition_Z, Condition_V, Condition_C};
`ifdef PSU_INTERRUPT_EN
                end else if (et_q && ((Irl == 4'hF) || (Irl > pil_q))) begin
                    trap_hit = 1'b1;
                    trap_tt  = 8'h10 + {4'h0, Irl};
`endif
                end

                if (trap_hit) begin
                    pend_d  = trap_tt;
                    state_d = et_q ? ST_TRAP : ST_ERROR;
                end else begin
                    if (WIM_Load) wim_d = ALU_Result & WIM_MASK;
                    if (TBR_Load) tba_d = ALU_Result[31:12];
                end
            end
            ST_TRAP: begin
                ps_d    = s_q;
                s_d     = 1'b1;
                et_d    = 1'b0;
                cwp_d   = cwp_dec;
                tt_d    = pend_q;
                state_d = ST_RUN;
            end
            ST_ERROR: begin
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= ST_RUN;
            icc_q   <= 4'h0;
            pil_q   <= 4'h0;
            s_q     <= 1'b1;
            ps_q    <= 1'b0;
            et_q    <= 1'b1;
            cwp_q   <= 5'd0;
            wim_q   <= 32'h0000_0002;
            tba_q   <= 20'h0;
            tt_q    <= 8'h00;
            pend_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            icc_q   <= icc_d;
            pil_q   <= pil_d;
            s_q     <= s_d;
            ps_q    <= ps_d;
            et_q    <= et_d;
            cwp_q   <= cwp_d;
            wim_q   <= wim_d;
            tba_q   <= tba_d;
            tt_q    <= tt_d;
            pend_q  <= pend_d;
        end
    end

    assign PSR        = {8'h00, icc_q, 8'h00, pil_q, s_q, ps_q, et_q, cwp_q};
    assign WIM        = wim_q;
    assign TBR        = {tba_q, tt_q, 4'b0000};
    assign CWP        = cwp_q;
    assign C_Out      = icc_q[0];
    assign Busy       = (state_q == ST_TRAP);
    assign Trap_Taken = (state_q == ST_TRAP);
    assign Error_Mode = (state_q == ST_ERROR);

endmodule

// File: tb/tb_processor_state_unit.sv
// Randomized bench for processor_state_unit with a behavioural model.
module tb_processor_state_unit;

    localparam int NW = 4;
    localparam logic [31:0] WMASK = 32'((64'd1 << NW) - 64'd1);

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic [31:0] ALU_Result;
    logic        Condition_N, Condition_Z, Condition_V, Condition_C;
    logic        ICC_Load, PSR_Load, WIM_Load, TBR_Load;
    logic        Save, Restore, Rett, Trap_Req;
    logic [7:0]  Trap_Type;
    logic [31:0] PSR, WIM, TBR;
    logic [4:0]  CWP;
    logic        C_Out, Busy, Trap_Taken, Error_Mode;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    processor_state_unit #(.NWINDOWS(NW)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .ALU_Result(ALU_Result),
        .Condition_N(Condition_N), .Condition_Z(Condition_Z),
        .Condition_V(Condition_V), .Condition_C(Condition_C),
        .ICC_Load(ICC_Load), .PSR_Load(PSR_Load),
        .WIM_Load(WIM_Load), .TBR_Load(TBR_Load),
        .Save(Save), .Restore(Restore), .Rett(Rett),
        .Trap_Req(Trap_Req), .Trap_Type(Trap_Type),
`ifdef PSU_INTERRUPT_EN
        .Irl(4'h0),
`endif
        .PSR(PSR), .WIM(WIM), .TBR(TBR), .CWP(CWP), .C_Out(C_Out),
        .Busy(Busy), .Trap_Taken(Trap_Taken), .Error_Mode(Error_Mode)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: mode 0=run, 1=trap, 2=error.
    int          m_mode;
    logic [3:0]  m_icc, m_pil;
    logic        m_s, m_ps, m_et;
    int          m_cwp;
    logic [31:0] m_wim;
    logic [19:0] m_tba;
    logic [7:0]  m_tt, m_pend;

    task automatic m_reset();
        m_mode = 0; m_icc = 4'h0; m_pil = 4'h0;
        m_s = 1'b1; m_ps = 1'b0; m_et = 1'b1; m_cwp = 0;
        m_wim = 32'h2; m_tba = 20'h0; m_tt = 8'h0; m_pend = 8'h0;
    endtask

    task automatic m_step();
        int tt;
        int nw;
        if (m_mode == 1) begin
            m_ps = m_s; m_s = 1'b1; m_et = 1'b0;
            m_cwp = (m_cwp + NW - 1) % NW;
            m_tt = m_pend; m_mode = 0;
        end else if (m_mode == 0) begin
            tt = -1;
            if (Trap_Req) tt = int'(Trap_Type);
            else if ((Save && Restore) || (Rett && m_et)) tt = 2;
            else if (PSR_Load && int'(ALU_Result[4:0]) >= NW) tt = 2;
            else if (Save) begin
                nw = (m_cwp + NW - 1) % NW;
                if (m_wim[nw]) tt = 5; else m_cwp = nw;
            end else if (Restore || Rett) begin
                nw = (m_cwp + 1) % NW;
                if (m_wim[nw]) tt = 6;
                else begin
                    m_cwp = nw;
                    if (Rett) begin m_s = m_ps; m_et = 1'b1; end
                end
            end else if (PSR_Load) begin
                m_icc = ALU_Result[23:20]; m_pil = ALU_Result[11:8];
                m_s = ALU_Result[7]; m_ps = ALU_Result[6];
                m_et = ALU_Result[5]; m_cwp = int'(ALU_Result[4:0]);
            end else if (ICC_Load) begin
                m_icc = {Condition_N, Condition_Z, Condition_V, Condition_C};
            end
            if (tt >= 0) begin
                m_pend = 8'(tt);
                m_mode = m_et ? 1 : 2;
            end else begin
                if (WIM_Load) m_wim = ALU_Result & WMASK;
                if (TBR_Load) m_tba = ALU_Result[31:12];
            end
        end
    endtask

    always @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) m_reset();
        else m_step();
    end

    function automatic logic [31:0] exp_psr();
        return {8'h00, m_icc, 8'h00, m_pil, m_s, m_ps, m_et, 5'(m_cwp)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("psr", PSR, exp_psr());
            chk("wim", WIM, m_wim);
            chk("tbr", TBR, {m_tba, m_tt, 4'h0});
            chk("cwp", 32'(CWP), 32'(m_cwp));
            chk("c_out", 32'(C_Out), 32'(m_icc[0]));
            chk("busy", 32'(Busy), 32'(m_mode == 1));
            chk("trap_taken", 32'(Trap_Taken), 32'(m_mode == 1));
            chk("error_mode", 32'(Error_Mode), 32'(m_mode == 2));
        end
    end

    task automatic idle();
        ALU_Result = 32'h0; Trap_Type = 8'h0;
        {Condition_N, Condition_Z, Condition_V, Condition_C} = 4'h0;
        {ICC_Load, PSR_Load, WIM_Load, TBR_Load} = 4'h0;
        {Save, Restore, Rett, Trap_Req} = 4'h0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic psr_load(input logic [31:0] v);
        PSR_Load = 1'b1; ALU_Result = v; tick();
    endtask

    task automatic pulse_reset();
        Reset_N = 1'b0;
        #2;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge Clk);
        #1;
        Reset_N = 1'b1;
        chk_en = 1'b1;
        chk("rst_psr", PSR, 32'h0000_00A0);
        chk("rst_wim", WIM, 32'h0000_0002);
        chk("rst_tbr", TBR, 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);

        ICC_Load = 1'b1;
        {Condition_N, Condition_Z, Condition_V, Condition_C} = 4'b1011;
        tick();
        chk("icc_psr", PSR, 32'h00B0_00A0);
        chk("icc_cout", 32'(C_Out), 32'h1);

        Save = 1'b1; tick();
        chk("save1_cwp", 32'(CWP), 32'd3);
        Save = 1'b1; tick();
        chk("save2_cwp", 32'(CWP), 32'd2);
        WIM_Load = 1'b1; ALU_Result = 32'h2; tick();
        Save = 1'b1; tick();
        chk("ovf_taken", 32'(Trap_Taken), 32'h1);
        chk("ovf_cwp_hold", 32'(CWP), 32'd2);
        tick();
        chk("ovf_psr", PSR, 32'h00B0_00C1);
        chk("ovf_tbr", TBR, 32'h0000_0050);
        chk("ovf_taken_end", 32'(Trap_Taken), 32'h0);

        psr_load(32'h0000_00A2);
        chk("psrld", PSR, 32'h0000_00A2);
        WIM_Load = 1'b1; psr_load(32'h0000_00A5);
        chk("ill_busy", 32'(Busy), 32'h1);
        chk("ill_psr_hold", PSR, 32'h0000_00A2);
        chk("ill_wim_hold", WIM, 32'h0000_0002);
        tick();
        chk("ill_psr", PSR, 32'h0000_00C1);
        chk("ill_tbr", TBR, 32'h0000_0020);

        Trap_Req = 1'b1; Trap_Type = 8'h80; tick();
        chk("err_mode", 32'(Error_Mode), 32'h1);
        chk("err_psr", PSR, 32'h0000_00C1);
        Save = 1'b1; tick();
        chk("err_stay", 32'(Error_Mode), 32'h1);
        chk("err_cwp", 32'(CWP), 32'd1);
        pulse_reset();
        chk("err_rst_mode", 32'(Error_Mode), 32'h0);
        chk("err_rst_psr", PSR, 32'h0000_00A0);
        Reset_N = 1'b1;

        TBR_Load = 1'b1; ALU_Result = 32'hABCD_E123; tick();
        chk("tbr_load", TBR, 32'hABCD_E000);
        WIM_Load = 1'b1; ALU_Result = 32'hFFFF_FFFF; tick();
        chk("wim_mask", WIM, 32'h0000_000F);
        WIM_Load = 1'b1; ALU_Result = 32'h0; tick();

        psr_load(32'h0000_0083);
        chk("rett_pre", PSR, 32'h0000_0083);
        Rett = 1'b1; tick();
        chk("rett_psr", PSR, 32'h0000_0020);
        Rett = 1'b1; tick();
        chk("rett_ill_busy", 32'(Busy), 32'h1);
        tick();
        chk("rett_ill_psr", PSR, 32'h0000_0083);
        chk("rett_ill_tbr", TBR, 32'hABCD_E020);

        psr_load(32'h0000_00A2);
        Trap_Req = 1'b1; Trap_Type = 8'h33; Save = 1'b1; tick();
        chk("tq_save_cwp", 32'(CWP), 32'd2);
        tick();
        chk("tq_cwp", 32'(CWP), 32'd1);
        chk("tq_tbr", TBR, 32'hABCD_E330);
        psr_load(32'h0000_00A2);
        Trap_Req = 1'b1; Trap_Type = 8'h44; tick();
        chk("mid_busy", 32'(Busy), 32'h1);
        pulse_reset();
        chk("mid_rst_busy", 32'(Busy), 32'h0);
        chk("mid_rst_psr", PSR, 32'h0000_00A0);
        chk("mid_rst_tbr", TBR, 32'h0);
        chk("mid_rst_wim", WIM, 32'h0000_0002);
        Reset_N = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 199) == 0) begin
                pulse_reset();
                Reset_N = 1'b1;
            end
            ALU_Result = $urandom;
            if ($urandom_range(0, 3) != 0)
                ALU_Result[4:0] = 5'($urandom_range(0, NW - 1));
            if ($urandom_range(0, 1) == 0) ALU_Result[5] = 1'b1;
            {Condition_N, Condition_Z, Condition_V, Condition_C} =
                4'($urandom_range(0, 15));
            ICC_Load = ($urandom_range(0, 2) == 0);
            PSR_Load = ($urandom_range(0, 5) == 0);
            WIM_Load = ($urandom_range(0, 5) == 0);
            TBR_Load = ($urandom_range(0, 5) == 0);
            Save     = ($urandom_range(0, 3) == 0);
            Restore  = ($urandom_range(0, 3) == 0);
            Rett     = ($urandom_range(0, 5) == 0);
            Trap_Req = ($urandom_range(0, 15) == 0);
            Trap_Type = 8'($urandom_range(0, 255));
            tick();
        end

        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
